// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
// Clear-sequencer states and packed-slice helpers used by the top and its read ports.
package reg_file_pkg;

    typedef enum logic [0:0] {
        CLEAR,
        READY
    } ClearState_t;

    localparam int unsigned DefaultAddressWidth  = 6;
    localparam int unsigned DefaultRegisterWidth = 16;
    localparam int unsigned DefaultReadPorts     = 2;

    // Low bit of port p inside a packed bus of width-sized slices.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: entry select, write bypass, zero-register and busy masking.
module register_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned AddressWidth   = DefaultAddressWidth,
    parameter int unsigned RegisterWidth  = DefaultRegisterWidth,
    parameter int unsigned Bypass         = 1,
    parameter int unsigned ZeroRegister   = 0,
    parameter int unsigned RegisterHeight = 1 << AddressWidth
) (
    input  logic                     i_busy,
    input  logic                     i_write_enable,
    input  logic [AddressWidth-1:0]  i_write_address,
    input  logic [RegisterWidth-1:0] i_write_data,
    input  logic [AddressWidth-1:0]  i_read_address,
    input  logic [RegisterWidth-1:0] i_registers [RegisterHeight],
    output logic [RegisterWidth-1:0] o_read_data
);

    logic w_bypass_hit;
    logic w_zero_hit;

    assign w_bypass_hit = (Bypass != 0) && i_write_enable && (i_read_address == i_write_address);
    assign w_zero_hit   = (ZeroRegister != 0) && (i_read_address == '0);

    // Later assignments take priority: busy beats zero-register beats bypass.
    always_comb begin
        o_read_data = i_registers[i_read_address];
        if (w_bypass_hit) begin
            o_read_data = i_write_data;
        end
        if (w_zero_hit) begin
            o_read_data = '0;
        end
        if (i_busy) begin
            o_read_data = '0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: one write port, ReadPorts combinational reads, clear sweep after reset.
// Storage, clear FSM and write logic live here; per-port read logic is in register_file_read_port.
module register_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned AddressWidth  = DefaultAddressWidth,
    parameter int unsigned RegisterWidth = DefaultRegisterWidth,
    parameter int unsigned ReadPorts     = DefaultReadPorts,
    parameter int unsigned Bypass        = 1,
    parameter int unsigned ZeroRegister  = 0
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_write_enable,
    input  logic [AddressWidth-1:0]            i_write_address,
    input  logic [RegisterWidth-1:0]           i_write_data,
    input  logic [ReadPorts*AddressWidth-1:0]  i_read_address,
    output logic [ReadPorts*RegisterWidth-1:0] o_read_data,
    output logic                               o_busy
);

    localparam int unsigned RegisterHeight = 1 << AddressWidth;

    ClearState_t               r_state;
    ClearState_t               w_state_next;
    logic [AddressWidth-1:0]   r_clear_index;
    logic [AddressWidth-1:0]   w_clear_index_next;
    logic                      r_busy;
    logic                      w_busy_next;
    logic                      w_write_allowed;
    logic [RegisterWidth-1:0]  r_registers [RegisterHeight];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= CLEAR;
            r_clear_index <= '0;
            r_busy        <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_clear_index <= w_clear_index_next;
            r_busy        <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_clear_index_next = r_clear_index;
        w_busy_next        = r_busy;
        unique case (r_state)
            CLEAR: begin
                w_clear_index_next = r_clear_index + 1'b1;
                if (&r_clear_index) begin
                    w_state_next = READY;
                    w_busy_next  = 1'b0;
                end
            end
            READY: begin
                w_busy_next = 1'b0;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // Writes during the sweep are dropped; entry 0 is read-only when hardwired to zero.
    assign w_write_allowed = i_write_enable && (r_state == READY) &&
                             !((ZeroRegister != 0) && (i_write_address == '0));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (r_state == CLEAR) begin
                r_registers[r_clear_index] <= '0;
            end else if (w_write_allowed) begin
                r_registers[i_write_address] <= i_write_data;
            end
        end
    end

    assign o_busy = r_busy;

    for (genvar p = 0; p < ReadPorts; p++) begin : g_read_port
        register_file_read_port #(
            .AddressWidth  (AddressWidth),
            .RegisterWidth (RegisterWidth),
            .Bypass        (Bypass),
            .ZeroRegister  (ZeroRegister),
            .RegisterHeight(RegisterHeight)
        ) u_read_port (
            .i_busy         (r_busy),
            .i_write_enable (i_write_enable),
            .i_write_address(i_write_address),
            .i_write_data   (i_write_data),
            .i_read_address (i_read_address[slice_lo(p, AddressWidth) +: AddressWidth]),
            .i_registers    (r_registers),
            .o_read_data    (o_read_data[slice_lo(p, RegisterWidth) +: RegisterWidth])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one 4-port bypassing instance and one
// 2-port non-bypassing zero-register instance sharing clock, reset and write port.
module tb_register_file_mp;

    localparam int unsigned AW = 6;
    localparam int unsigned RW = 16;

    logic            clk;
    logic            reset;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [RW-1:0]   wdata;
    logic [4*AW-1:0] raddr_a;
    logic [4*RW-1:0] rdata_a;
    logic            busy_a;
    logic [2*AW-1:0] raddr_b;
    logic [2*RW-1:0] rdata_b;
    logic            busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_mp #(
        .AddressWidth (AW),
        .RegisterWidth(RW),
        .ReadPorts    (4),
        .Bypass       (1),
        .ZeroRegister (0)
    ) u_dut_a (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_write_enable (we),
        .i_write_address(waddr),
        .i_write_data   (wdata),
        .i_read_address (raddr_a),
        .o_read_data    (rdata_a),
        .o_busy         (busy_a)
    );

    register_file_mp #(
        .AddressWidth (AW),
        .RegisterWidth(RW),
        .ReadPorts    (2),
        .Bypass       (0),
        .ZeroRegister (1)
    ) u_dut_b (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_write_enable (we),
        .i_write_address(waddr),
        .i_write_data   (wdata),
        .i_read_address (raddr_b),
        .o_read_data    (rdata_b),
        .o_busy         (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] port_a(input int p);
        return rdata_a[p*RW +: RW];
    endfunction

    function automatic logic [RW-1:0] port_b(input int p);
        return rdata_b[p*RW +: RW];
    endfunction

    task automatic set_all_a(input logic [AW-1:0] addr);
        for (int p = 0; p < 4; p++) raddr_a[p*AW +: AW] = addr;
    endtask

    // Counts edges until Busy falls, bounded so a stuck sweep fails instead of hanging.
    task automatic run_sweep(output int edges, output logic any_nonzero);
        edges       = 0;
        any_nonzero = 1'b0;
        while (busy_a && edges < 200) begin
            if (rdata_a != '0 || rdata_b != '0) any_nonzero = 1'b1;
            tick();
            edges++;
        end
    endtask

    int   edges;
    logic nz;

    initial begin
        reset   = 1'b1;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = '0;
        raddr_b = '0;

        // Reset state
        tick();
        check_eq("reset_busy_a", 32'(busy_a), 32'd1);
        check_eq("reset_busy_b", 32'(busy_b), 32'd1);
        check_eq("reset_rdata_a", 32'(rdata_a == '0), 32'd1);

        // Full sweep with idle inputs
        reset = 1'b0;
        run_sweep(edges, nz);
        check_eq("sweep_len", 32'(edges), 32'd64);
        check_eq("sweep_busy_b", 32'(busy_b), 32'd0);
        check_eq("sweep_reads_zero", 32'(nz), 32'd0);
        set_all_a(6'd63);
        #1;
        check_eq("post_sweep_zero", 32'(rdata_a == '0), 32'd1);

        // Restart mid-sweep while attempting writes that must be dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we    = 1'b1;
        waddr = 6'd7;
        wdata = 16'hAAAA;
        set_all_a(6'd7);
        #1;
        check_eq("busy_masks_bypass", 32'(port_a(0)), 32'h0);
        for (int i = 0; i < 29; i++) tick();
        check_eq("busy_at_edge29", 32'(busy_a), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_sweep(edges, nz);
        check_eq("restart_sweep_len", 32'(edges), 32'd64);
        check_eq("restart_reads_zero", 32'(nz), 32'd0);
        we = 1'b0;
        #1;
        check_eq("dropped_write_addr7", 32'(port_a(0)), 32'h0);

        // Bypass vs. no bypass on a plain write
        we    = 1'b1;
        waddr = 6'd5;
        wdata = 16'hBEEF;
        raddr_a[0 +: AW] = 6'd5;
        raddr_b[0 +: AW] = 6'd5;
        #1;
        check_eq("bypass_same_cycle", 32'(port_a(0)), 32'hBEEF);
        check_eq("nobypass_old_value", 32'(port_b(0)), 32'h0);
        tick();
        we = 1'b0;
        #1;
        check_eq("bypass_after_edge", 32'(port_a(0)), 32'hBEEF);
        check_eq("nobypass_after_edge", 32'(port_b(0)), 32'hBEEF);

        // Zero register: dut_b ignores writes to 0, dut_a stores them
        we    = 1'b1;
        waddr = 6'd0;
        wdata = 16'h1234;
        raddr_b = '0;
        raddr_a[AW +: AW] = 6'd0;
        #1;
        check_eq("zero_reg_p0_write_cycle", 32'(port_b(0)), 32'h0);
        check_eq("zero_reg_p1_write_cycle", 32'(port_b(1)), 32'h0);
        check_eq("nonzero_reg_bypass", 32'(port_a(1)), 32'h1234);
        tick();
        we = 1'b0;
        #1;
        check_eq("zero_reg_p0_after", 32'(port_b(0)), 32'h0);
        check_eq("zero_reg_p1_after", 32'(port_b(1)), 32'h0);
        check_eq("nonzero_reg_stored", 32'(port_a(1)), 32'h1234);

        // Four ports on one address with simultaneous bypass; port 2 on a neighbour
        we    = 1'b1;
        waddr = 6'd9;
        wdata = 16'h0F0F;
        set_all_a(6'd9);
        raddr_a[2*AW +: AW] = 6'd10;
        raddr_b[AW +: AW]   = 6'd9;
        #1;
        check_eq("mp_bypass_p0", 32'(port_a(0)), 32'h0F0F);
        check_eq("mp_bypass_p1", 32'(port_a(1)), 32'h0F0F);
        check_eq("mp_neighbour_p2", 32'(port_a(2)), 32'h0);
        check_eq("mp_bypass_p3", 32'(port_a(3)), 32'h0F0F);
        check_eq("mp_nobypass_b", 32'(port_b(1)), 32'h0);
        tick();
        we = 1'b0;
        #1;
        check_eq("mp_stored_p3", 32'(port_a(3)), 32'h0F0F);
        check_eq("mp_neighbour_after", 32'(port_a(2)), 32'h0);

        // Independent addresses on each port after a short write burst
        we = 1'b1;
        waddr = 6'd10; wdata = 16'h1111; tick();
        waddr = 6'd63; wdata = 16'hC0DE; tick();
        we = 1'b0;
        raddr_a = {6'd5, 6'd63, 6'd10, 6'd9};
        #1;
        check_eq("indep_p0", 32'(port_a(0)), 32'h0F0F);
        check_eq("indep_p1", 32'(port_a(1)), 32'h1111);
        check_eq("indep_p2", 32'(port_a(2)), 32'hC0DE);
        check_eq("indep_p3", 32'(port_a(3)), 32'hBEEF);
        check_eq("ready_busy", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
